// File: rtl/half_adder.sv
// Single-bit half adder: combinational sum/carry, a registered copy of both,
// and a saturating count of clock edges that sampled a carry.
module half_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Arithmetic path: pure gates, no dependence on clock, reset or clear.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

    // Counter next state: clear beats a carry; saturate rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (c && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // Registered copy of the sum/carry and the counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            c_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_q   <= s;
            c_q   <= c;
            cnt_q <= cnt_d;
        end
    end

    // Saturation flag is decoded directly from the stored count.
    always_comb begin
        carry_cnt = cnt_q;
        cnt_sat   = (cnt_q == CntMax);
    end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a default-width instance and a 2-bit-counter instance
// share the same stimulus; an integer model is compared every cycle, and
// directed literal expectations pin the model.
module tb_half_adder;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        clr;

    logic        s16, c16, sq16, cq16, sat16;
    logic [15:0] cnt16;
    logic        s2, c2, sq2, cq2, sat2;
    logic [1:0]  cnt2;

    int checks;
    int errors;
    bit chk_en;

    // Model state (plain integers, cleared asynchronously like the design).
    int m_sq, m_cq, m_cnt16, m_cnt2;

    half_adder #(.CNT_W(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .s         (s16),
        .c         (c16),
        .s_q       (sq16),
        .c_q       (cq16),
        .carry_cnt (cnt16),
        .cnt_sat   (sat16)
    );

    half_adder #(.CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .s         (s2),
        .c         (c2),
        .s_q       (sq2),
        .c_q       (cq2),
        .carry_cnt (cnt2),
        .cnt_sat   (sat2)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a+b arithmetic and a saturating integer count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sq    = 0;
            m_cq    = 0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            m_sq = (int'(a) + int'(b)) % 2;
            m_cq = (int'(a) + int'(b)) / 2;
            if (clr) begin
                m_cnt16 = 0;
                m_cnt2  = 0;
            end else if (m_cq == 1) begin
                if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
        end
    end

    // Compare process, on the inactive clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sum16_vs_add", 32'({c16, s16}), 32'(int'(a) + int'(b)));
            chk("sum2_vs_add", 32'({c2, s2}), 32'(int'(a) + int'(b)));
            chk("s_q16", 32'(sq16), 32'(m_sq));
            chk("c_q16", 32'(cq16), 32'(m_cq));
            chk("cnt16", 32'(cnt16), 32'(m_cnt16));
            chk("sat16", 32'(sat16), 32'(m_cnt16 == 65535));
            chk("s_q2", 32'(sq2), 32'(m_sq));
            chk("c_q2", 32'(cq2), 32'(m_cq));
            chk("cnt2", 32'(cnt2), 32'(m_cnt2));
            chk("sat2", 32'(sat2), 32'(m_cnt2 == 3));
        end
    end

    initial begin
        logic [3:0] exp_s;
        logic [3:0] exp_c;
        logic [1:0] ab;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        clk_en = 1'b0;
        clr    = 1'b0;
        exp_s  = 4'b0110;
        exp_c  = 4'b1000;

        // No clock, reset undriven: truth-table sweep.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a  = ab[1];
            b  = ab[0];
            #50;
            chk("tt_s", 32'(s16), 32'(exp_s[i]));
            chk("tt_c", 32'(c16), 32'(exp_c[i]));
            chk("tt_s_w2", 32'(s2), 32'(exp_s[i]));
            #50;
        end

        // Asynchronous reset with the clock still stopped.
        rst_n = 1'b0;
        #1;
        chk("rst_s_q", 32'(sq16), 32'd0);
        chk("rst_c_q", 32'(cq16), 32'd0);
        chk("rst_cnt", 32'(cnt16), 32'd0);
        chk("rst_sat", 32'(sat16), 32'd0);
        chk("rst_c_passes", 32'(c16), 32'd1);
        chk_en = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // a=b=1 for five edges.
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("run_c_q", 32'(cq16), 32'd1);
            chk("run_s_q", 32'(sq16), 32'd0);
            chk("run_cnt", 32'(cnt16), 32'(k));
            chk("run_cnt2", 32'(cnt2), 32'(k < 3 ? k : 3));
            chk("run_sat2", 32'(sat2), 32'(k >= 3));
        end

        // a=1, b=0 for one edge: count holds.
        b = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_s_q", 32'(sq16), 32'd1);
        chk("hold_c_q", 32'(cq16), 32'd0);
        chk("hold_cnt", 32'(cnt16), 32'd5);
        chk("hold_sat2", 32'(sat2), 32'd1);

        // Clear wins over a simultaneous carry.
        b   = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_cnt", 32'(cnt16), 32'd0);
        chk("clr_cnt2", 32'(cnt2), 32'd0);
        chk("clr_sat2", 32'(sat2), 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("post_clr_cnt", 32'(cnt16), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_cnt", 32'(cnt16), 32'd3);
        chk("pre_rst_c_q", 32'(cq16), 32'd1);

        // Reset mid-cycle: state clears before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(cnt16), 32'd0);
        chk("mid_rst_c_q", 32'(cq16), 32'd0);
        chk("mid_rst_cnt2", 32'(cnt2), 32'd0);
        chk("mid_rst_c", 32'(c16), 32'd1);
        a = 1'b0;
        #1;
        chk("mid_rst_c_follow", 32'(c16), 32'd0);
        chk("mid_rst_s_follow", 32'(s16), 32'd1);
        @(posedge clk);
        #1;
        chk("in_rst_s_q", 32'(sq16), 32'd0);
        rst_n = 1'b1;

        // A few mixed vectors after release, checked by the model.
        for (int k = 0; k < 12; k++) begin
            ab  = 2'(k % 4);
            a   = ab[1];
            b   = ab[0];
            clr = (k == 9);
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
